stopwatch_lap: RTL

Up-counting mm:ss stopwatch with start/pause, lap-hold and clear; the count-up counterpart of the countdown timer mode in the clock project. Takes debounced one-cycle button pulses from the shared button block and drives a 16-bit BCD value to the FND display mux. Contains its own 1 s prescaler, so a stopped watch holds its sub-second fraction.

---
 rtl/stopwatch_lap_pkg.sv | 20 ++
 rtl/stopwatch_lap_if.sv | 27 ++
 rtl/stopwatch_lap_bcd_upcounter_60.sv | 52 +++++
 rtl/stopwatch_lap.sv | 136 +++++++++++++
 4 files changed

// File: rtl/stopwatch_lap_pkg.sv
// Shared definitions for the mm:ss lap stopwatch: FSM encoding, button map,
// BCD digit type and the two time constants the datapath compares against.
package stopwatch_lap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int BTN_START = 0;
    localparam int BTN_LAP   = 1;
    localparam int BTN_CLEAR = 2;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] TIME_ZERO = 16'h0000;
    localparam logic [15:0] TIME_MAX  = 16'h5959;

endpackage

// File: rtl/stopwatch_lap_if.sv
// Button-in / display-out bundle between the button block, the stopwatch
// and the FND display mux.
interface stopwatch_lap_if;

    logic [3:0]  btn_pedge;
    logic [15:0] value;
    logic        running;
    logic        lap_active;
    logic        overflow;

    modport master (
        output btn_pedge,
        input  value,
        input  running,
        input  lap_active,
        input  overflow
    );

    modport slave (
        input  btn_pedge,
        output value,
        output running,
        output lap_active,
        output overflow
    );

endinterface

// File: rtl/stopwatch_lap_bcd_upcounter_60.sv
// Two-digit BCD 00..59 counter. With sat set it sticks at 59 instead of
// wrapping, and carry is only raised on a genuine 59 -> 00 rollover.
module bcd_upcounter_60
    import stopwatch_lap_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clr,
    input  logic       inc,
    input  logic       sat,
    output bcd_digit_t ones,
    output bcd_digit_t tens,
    output logic       carry
);

    bcd_digit_t ones_q, ones_d;
    bcd_digit_t tens_q, tens_d;
    logic       at_max;

    assign at_max = (ones_q == 4'd9) && (tens_q == 4'd5);
    assign carry  = inc && at_max && !sat && !clr;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (inc && !(at_max && sat)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd5) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;

endmodule

// File: rtl/stopwatch_lap.sv
// Up-counting mm:ss stopwatch with start/pause, lap hold and clear. The 1 s
// prescaler only advances in RUN, so pausing keeps the sub-second fraction.
module stopwatch_lap
    import stopwatch_lap_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic           clk,
    input  logic           reset_p,
    stopwatch_lap_if.slave bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_e         state_q, state_d;
    logic [PW-1:0]  prescaler_q, prescaler_d;
    logic [15:0]    lap_q, lap_d;
    logic           lap_active_q, lap_active_d;
    logic           overflow_q, overflow_d;

    logic           btn_start, btn_lap, btn_clear;
    logic           unused_btn;
    logic           tick, ovf_tick, lap_press;
    logic [15:0]    count;

    bcd_digit_t     sec_ones, sec_tens, min_ones, min_tens;
    logic           sec_carry, unused_min_carry, min_at_max;

    assign btn_start  = bus.btn_pedge[BTN_START];
    assign btn_lap    = bus.btn_pedge[BTN_LAP];
    assign btn_clear  = bus.btn_pedge[BTN_CLEAR];
    assign unused_btn = bus.btn_pedge[3];

    assign count      = {min_tens, min_ones, sec_tens, sec_ones};
    assign min_at_max = (min_tens == 4'd5) && (min_ones == 4'd9);

    // Tick is judged on the pre-press state, so a pausing start on the same
    // edge still lets this second's increment through.
    assign tick      = (state_q == ST_RUN) && (prescaler_q == PRE_LAST);
    assign ovf_tick  = tick && (count == TIME_MAX);
    assign lap_press = btn_lap && !btn_start && !btn_clear;

    bcd_upcounter_60 u_seconds (
        .clk     (clk),
        .reset_p (reset_p),
        .clr     (btn_clear),
        .inc     (tick),
        .sat     (min_at_max),
        .ones    (sec_ones),
        .tens    (sec_tens),
        .carry   (sec_carry)
    );

    bcd_upcounter_60 u_minutes (
        .clk     (clk),
        .reset_p (reset_p),
        .clr     (btn_clear),
        .inc     (sec_carry),
        .sat     (1'b1),
        .ones    (min_ones),
        .tens    (min_tens),
        .carry   (unused_min_carry)
    );

    always_comb begin
        state_d = state_q;
        if (btn_clear) begin
            state_d = ST_IDLE;
        end else if (btn_start) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = overflow_q ? ST_PAUSE : ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (ovf_tick) begin
            state_d = ST_PAUSE;
        end
    end

    always_comb begin
        prescaler_d = prescaler_q;
        if (btn_clear || state_q == ST_IDLE) begin
            prescaler_d = '0;
        end else if (state_q == ST_RUN) begin
            prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        end
    end

    always_comb begin
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        if (btn_clear) begin
            lap_d        = TIME_ZERO;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            if (ovf_tick) begin
                overflow_d = 1'b1;
            end
            // Capture takes the registered count, not the value this edge's tick produces.
            if (lap_press) begin
                if (lap_active_q) begin
                    lap_active_d = 1'b0;
                end else if (state_q == ST_RUN) begin
                    lap_d        = count;
                    lap_active_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q      <= ST_IDLE;
            prescaler_q  <= '0;
            lap_q        <= TIME_ZERO;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescaler_q  <= prescaler_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.value      = lap_active_q ? lap_q : count;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.lap_active = lap_active_q;
    assign bus.overflow   = overflow_q;

endmodule
